rom_port_arbiter: RTL and testbench



---
 rtl/rom_port_arbiter_pkg.sv | 20 ++
 rtl/rom_port_arbiter_if.sv | 36 +++
 rtl/rom_arb_prio.sv | 39 +++
 rtl/rom_port_arbiter.sv | 78 +++++++
 tb/tb_rom_port_arbiter.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/rom_port_arbiter_pkg.sv
// rtl/rom_port_arbiter_pkg.sv - shared types and defaults for the boot ROM port arbiter
package rom_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2,
        OWN_DERR = 2'd3
    } owner_e;

    localparam logic [31:0] NOP_INSN       = 32'h0000_0013;
    localparam int          ADDR_W_DEF     = 3;
    localparam int          STARVE_MAX_DEF = 3;
    localparam int          CNT_W_DEF      = 16;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/rom_port_arbiter_if.sv
// rtl/rom_port_arbiter_if.sv - fetch, data and memory signals between requesters, arbiter and ROM
interface rom_port_arbiter_if #(
    parameter int ADDR_W = 3
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;

    logic              d_req;
    logic [31:0]       d_addr;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              d_err;

    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_addr, mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_en, mem_addr
    );

    modport master (
        output if_req, if_addr, d_req, d_addr, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_en, mem_addr
    );

endinterface

// File: rtl/rom_arb_prio.sv
// rtl/rom_arb_prio.sv - data-priority grant decision with bounded fetch starvation
module rom_arb_prio
    import rom_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic d_req,
    output logic if_gnt,
    output logic d_gnt
);

    localparam int            SW   = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    logic [SW-1:0] starve_cnt;
    logic          starved;

    assign starved = (starve_cnt == SMAX);

    always_comb begin
        if_gnt = if_req && (!d_req || starved);
        d_gnt  = d_req && !if_gnt;
    end

    // Counts only cycles where fetch asked and lost; any fetch win or idle fetch restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!if_req || if_gnt) begin
            starve_cnt <= '0;
        end else if (!starved) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// rtl/rom_port_arbiter.sv - shares one single-read-port ROM between fetch and data load
module rom_port_arbiter
    import rom_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    rom_port_arbiter_if.slave    bus,
    output logic [CNT_W-1:0]     conflict_cnt
);

    owner_e owner;
    owner_e owner_nxt;
    logic   live;
    logic   if_gnt;
    logic   d_gnt;
    logic   d_mis;
    logic   unused_addr_bits;

    assign live             = !rst;
    assign unused_addr_bits = ^{bus.if_addr[31:ADDR_W+2], bus.if_addr[1:0],
                                bus.d_addr[31:ADDR_W+2]};

    // Requests are masked during reset so nothing is granted whose response would be dropped.
    rom_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk    (clk),
        .rst    (rst),
        .if_req (bus.if_req & live),
        .d_req  (bus.d_req & live),
        .if_gnt (if_gnt),
        .d_gnt  (d_gnt)
    );

    always_comb begin
        d_mis        = is_misaligned(bus.d_addr);
        bus.if_gnt   = if_gnt;
        bus.d_gnt    = d_gnt;
        bus.mem_en   = if_gnt | (d_gnt & !d_mis);
        bus.mem_addr = if_gnt ? bus.if_addr[ADDR_W+1:2] : bus.d_addr[ADDR_W+1:2];
        owner_nxt    = OWN_NONE;
        if (if_gnt) begin
            owner_nxt = OWN_IF;
        end else if (d_gnt) begin
            owner_nxt = d_mis ? OWN_DERR : OWN_D;
        end
    end

    // Responses follow the owner of the previous cycle's grant; an in-flight read dies with reset.
    always_comb begin
        bus.if_rvalid = live && (owner == OWN_IF);
        bus.d_rvalid  = live && ((owner == OWN_D) || (owner == OWN_DERR));
        bus.d_err     = live && (owner == OWN_DERR);
        bus.if_rdata  = (live && (owner == OWN_IF)) ? bus.mem_rdata : 32'h0;
        bus.d_rdata   = (live && (owner == OWN_D))  ? bus.mem_rdata : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner <= OWN_NONE;
        end else begin
            owner <= owner_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (bus.if_req && bus.d_req && (conflict_cnt != {CNT_W{1'b1}})) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb/tb_rom_port_arbiter.sv - directed table and sequence bench for rom_port_arbiter
module tb_rom_port_arbiter;

    localparam logic [31:0] M0 = 32'h1000_02b7;
    localparam logic [31:0] M1 = 32'h0210_0313;
    localparam logic [31:0] M2 = 32'h0062_a023;
    localparam logic [31:0] M3 = 32'h0000_006f;
    localparam logic [31:0] M7 = 32'hc0de_0007;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] conflict_cnt;
    logic [31:0] mem [8];
    int          total = 0;
    int          bad   = 0;

    rom_port_arbiter_if #(.ADDR_W(3)) bus ();

    rom_port_arbiter #(
        .ADDR_W     (3),
        .STARVE_MAX (3),
        .CNT_W      (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        bus.mem_rdata <= bus.mem_en ? mem[bus.mem_addr] : 32'hdead_beef;
    end

    typedef struct {
        logic        rst;
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic [31:0] da;
        logic        eig;
        logic        edg;
        logic        emen;
        logic [2:0]  emaddr;
        logic        eirv;
        logic [31:0] eird;
        logic        edrv;
        logic        ederr;
        logic [31:0] edrd;
    } vec_t;

    vec_t vt [16];

    function automatic vec_t mk(input logic r, input logic ir, input logic [31:0] ia,
                                input logic dr, input logic [31:0] da,
                                input logic eig, input logic edg, input logic emen,
                                input logic [2:0] emaddr, input logic eirv,
                                input logic [31:0] eird, input logic edrv,
                                input logic ederr, input logic [31:0] edrd);
        vec_t v;
        v = '{r, ir, ia, dr, da, eig, edg, emen, emaddr, eirv, eird, edrv, ederr, edrd};
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic ir, input logic [31:0] ia,
                         input logic dr, input logic [31:0] da);
        @(negedge clk);
        rst         = r;
        bus.if_req  = ir;
        bus.if_addr = ia;
        bus.d_req   = dr;
        bus.d_addr  = da;
        #1;
    endtask

    initial begin
        bus.if_req  = 1'b0;
        bus.if_addr = 32'h0;
        bus.d_req   = 1'b0;
        bus.d_addr  = 32'h0;
        mem[0] = M0; mem[1] = M1; mem[2] = M2; mem[3] = M3;
        mem[4] = 32'hc0de_0004; mem[5] = 32'hc0de_0005; mem[6] = 32'hc0de_0006; mem[7] = M7;

        vt[0]  = mk(1, 0, 32'h0,         0, 32'h0,  0, 0, 0, 0, 0, 0,  0, 0, 0);
        vt[1]  = mk(1, 0, 32'h0,         0, 32'h0,  0, 0, 0, 0, 0, 0,  0, 0, 0);
        vt[2]  = mk(0, 1, 32'h0,         0, 32'h0,  1, 0, 1, 0, 0, 0,  0, 0, 0);
        vt[3]  = mk(0, 1, 32'h4,         0, 32'h0,  1, 0, 1, 1, 1, M0, 0, 0, 0);
        vt[4]  = mk(0, 1, 32'h8,         0, 32'h0,  1, 0, 1, 2, 1, M1, 0, 0, 0);
        vt[5]  = mk(0, 1, 32'hc,         0, 32'h0,  1, 0, 1, 3, 1, M2, 0, 0, 0);
        vt[6]  = mk(0, 0, 32'h0,         0, 32'h0,  0, 0, 0, 0, 1, M3, 0, 0, 0);
        vt[7]  = mk(0, 0, 32'h0,         0, 32'h0,  0, 0, 0, 0, 0, 0,  0, 0, 0);
        vt[8]  = mk(0, 1, 32'h0,         1, 32'h8,  0, 1, 1, 2, 0, 0,  0, 0, 0);
        vt[9]  = mk(0, 1, 32'h0,         0, 32'h0,  1, 0, 1, 0, 0, 0,  1, 0, M2);
        vt[10] = mk(0, 0, 32'h0,         0, 32'h0,  0, 0, 0, 0, 1, M0, 0, 0, 0);
        vt[11] = mk(0, 0, 32'h0,         1, 32'h6,  0, 1, 0, 0, 0, 0,  0, 0, 0);
        vt[12] = mk(0, 0, 32'h0,         0, 32'h0,  0, 0, 0, 0, 0, 0,  1, 1, 0);
        vt[13] = mk(0, 1, 32'h1000_0020, 0, 32'h0,  1, 0, 1, 0, 0, 0,  0, 0, 0);
        vt[14] = mk(0, 0, 32'h0,         1, 32'h1c, 0, 1, 1, 7, 1, M0, 0, 0, 0);
        vt[15] = mk(0, 0, 32'h0,         0, 32'h0,  0, 0, 0, 0, 0, 0,  1, 0, M7);

        for (int i = 0; i < 16; i++) begin
            drive(vt[i].rst, vt[i].ir, vt[i].ia, vt[i].dr, vt[i].da);
            chk("if_gnt",    i, 32'(bus.if_gnt),    32'(vt[i].eig));
            chk("d_gnt",     i, 32'(bus.d_gnt),     32'(vt[i].edg));
            chk("mem_en",    i, 32'(bus.mem_en),    32'(vt[i].emen));
            if (vt[i].emen) chk("mem_addr", i, 32'(bus.mem_addr), 32'(vt[i].emaddr));
            chk("if_rvalid", i, 32'(bus.if_rvalid), 32'(vt[i].eirv));
            chk("if_rdata",  i, bus.if_rdata,       vt[i].eird);
            chk("d_rvalid",  i, 32'(bus.d_rvalid),  32'(vt[i].edrv));
            chk("d_err",     i, 32'(bus.d_err),     32'(vt[i].ederr));
            chk("d_rdata",   i, bus.d_rdata,        vt[i].edrd);
            if (i == 1) chk("conflict_rst", i, 32'(conflict_cnt), 32'd0);
        end
        chk("conflict_after_pair", 0, 32'(conflict_cnt), 32'd1);

        // Both requesters held: starvation forces one fetch win on the fourth cycle.
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 32'h4, 1, 32'hc);
            chk("starve_if_gnt",   i, 32'(bus.if_gnt),    32'(i == 3));
            chk("starve_d_gnt",    i, 32'(bus.d_gnt),     32'(i != 3));
            chk("starve_if_rvalid", i, 32'(bus.if_rvalid), 32'(i == 4));
            chk("starve_d_rvalid", i, 32'(bus.d_rvalid),  32'(i > 0 && i != 4));
            if (i == 4) chk("starve_if_rdata", i, bus.if_rdata, M1);
            if (i == 2) chk("starve_d_rdata",  i, bus.d_rdata,  M3);
        end
        drive(0, 0, 32'h0, 0, 32'h0);
        chk("starve_tail_d_rvalid", 0, 32'(bus.d_rvalid), 32'd1);
        chk("starve_tail_d_rdata",  0, bus.d_rdata, M3);
        chk("conflict_after_starve", 0, 32'(conflict_cnt), 32'd7);

        // Reset lands while a data read is in flight.
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 32'h0, 1, 32'h8);
            chk("pre_rst_d_gnt", i, 32'(bus.d_gnt), 32'd1);
        end
        drive(1, 0, 32'h0, 0, 32'h0);
        chk("rst_d_rvalid", 0, 32'(bus.d_rvalid), 32'd0);
        chk("rst_d_rdata",  0, bus.d_rdata, 32'h0);
        drive(0, 0, 32'h0, 0, 32'h0);
        chk("post_rst_d_rvalid", 0, 32'(bus.d_rvalid), 32'd0);
        chk("post_rst_conflict", 0, 32'(conflict_cnt), 32'd0);
        drive(0, 1, 32'h0, 1, 32'h8);
        chk("post_rst_d_gnt",  0, 32'(bus.d_gnt),  32'd1);
        chk("post_rst_if_gnt", 0, 32'(bus.if_gnt), 32'd0);
        drive(0, 0, 32'h0, 0, 32'h0);
        chk("post_rst_rsp_valid", 0, 32'(bus.d_rvalid), 32'd1);
        chk("post_rst_rsp_data",  0, bus.d_rdata, M2);
        chk("post_rst_conflict1", 0, 32'(conflict_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
